mips32_mem_arbiter: RTL and testbench

//  Single-port unified memory arbiter for the MIPS32 pipeline. Shares one synchronous
//  RAM port between instruction fetch (IF), data access (DM, MEM stage) and a debug/loader

---
 rtl/mips32_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_arbiter.sv
// Single-port RAM arbiter sharing one synchronous memory port between IF, DM and DBG.
// Optional IF starvation guard is compiled in with `define ARB_STARVE_GUARD_EN.
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_lock,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   if_rvalid_q, dm_rvalid_q, dbg_rvalid_q;
  logic   starve_force_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_force_s = (starve_cnt_q >= SCW'(STARVE_MAX));

  // Count consecutive unlocked IF denials; saturate at the limit
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (state_q != LOCKED && starve_cnt_q < SCW'(STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + SCW'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign starve_force_s = 1'b0;
`endif

  // Grant decision; held off during reset so nothing reaches the RAM
  always_comb begin
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      dbg_gnt = 1'b0;
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
    end else if (state_q != LOCKED) begin
      if (if_req && starve_force_s) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else begin
        if_gnt = 1'b0;
      end
    end else begin
      dbg_gnt = 1'b0;
    end
  end

  // Steer the granted requester onto the RAM port
  always_comb begin
    mem_en    = if_gnt | dm_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case ({dbg_gnt, dm_gnt, if_gnt})
      3'b100: begin
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      3'b010: begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      3'b001: begin
        mem_addr  = if_addr;
      end
      default: begin
        mem_we    = 1'b0;
      end
    endcase
  end

  // Lock is sampled at the edge, so grants change the cycle after dbg_lock moves
  always_comb begin
    state_d = state_q;
    if (dbg_lock) begin
      state_d = LOCKED;
    end else begin
      case (state_q)
        IDLE:    state_d = (if_req | dm_req | dbg_req) ? SERVE : IDLE;
        SERVE:   state_d = (if_req | dm_req | dbg_req) ? SERVE : IDLE;
        LOCKED:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      if_rvalid_q  <= if_gnt;
      dm_rvalid_q  <= dm_gnt & ~dm_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign dm_rvalid  = dm_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign rdata      = (if_rvalid_q | dm_rvalid_q | dbg_rvalid_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed scenarios plus a randomized
// run against a cycle-level reference model; honours ARB_STARVE_GUARD_EN if defined.
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk, rst;
  logic if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] ram [1024];
  int vectors = 0;
  int errors = 0;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM behind the arbiter
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid, mem_en, mem_we} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid, mem_en, mem_we});
    end
    vectors++;
    if ({rdata, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h expected 0", rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    dm_req = 1'b1; dm_addr = 10'd5;
    @(negedge clk);
    vectors++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL reset_pre_gnt: got %b expected 1", dm_gnt); end
    step();
    vectors++;
    if (dm_rvalid !== 1'b1) begin errors++; $display("FAIL reset_pre_rvalid: got %b expected 1", dm_rvalid); end
    rst = 1'b1;
    #1;
    vectors++;
    if ({if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid, mem_en} !== 7'h00 || rdata !== '0) begin
      errors++; $display("FAIL reset_mid_read: ctrl=%b rdata=%h expected all 0",
        {if_gnt, dm_gnt, dbg_gnt, if_rvalid, dm_rvalid, dbg_rvalid, mem_en}, rdata);
    end
    step();
    vectors++;
    if ({dm_gnt, dm_rvalid, mem_en} !== 3'b000 || rdata !== '0) begin
      errors++; $display("FAIL reset_next_edge: ctrl=%b rdata=%h expected 0", {dm_gnt, dm_rvalid, mem_en}, rdata);
    end
    idle_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_dbg_lock_load();
    dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd120; dbg_wdata = 32'd55;
    if_req = 1'b1; if_addr = 10'd120;
    @(negedge clk);
    vectors++;
    if ({dbg_gnt, if_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 10'd120, 32'd55}) begin
      errors++; $display("FAIL lock_write: dbg_gnt=%b if_gnt=%b we=%b addr=%0d wdata=%0d expected 1 0 1 120 55",
        dbg_gnt, if_gnt, mem_we, mem_addr, mem_wdata);
    end
    step();
    dbg_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dbg_gnt, if_gnt, mem_we} !== 3'b100) begin
      errors++; $display("FAIL lock_read_gnt: dbg/if/we=%b expected 100", {dbg_gnt, if_gnt, mem_we});
    end
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dbg_rvalid, if_gnt} !== 2'b10 || rdata !== 32'd55) begin
      errors++; $display("FAIL lock_readback: rvalid/if_gnt=%b rdata=%0d expected 10 55", {dbg_rvalid, if_gnt}, rdata);
    end
    step();
    dbg_lock = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if_gnt, dbg_rvalid} !== 2'b00) begin
      errors++; $display("FAIL lock_release_cycle: if_gnt/dbg_rvalid=%b expected 00", {if_gnt, dbg_rvalid});
    end
    step();
    @(negedge clk);
    vectors++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL lock_if_resume: got %b expected 1", if_gnt); end
    step();
    if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (if_rvalid !== 1'b1 || rdata !== 32'd55) begin
      errors++; $display("FAIL lock_if_data: if_rvalid=%b rdata=%0d expected 1 55", if_rvalid, rdata);
    end
    step();
  endtask

  task automatic test_write_read();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd121; dm_wdata = 32'd100;
    @(negedge clk);
    vectors++;
    if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd121, 32'd100}) begin
      errors++; $display("FAIL wr_port: gnt/en/we=%b addr=%0d wdata=%0d expected 111 121 100",
        {dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    step();
    dm_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dm_gnt, dm_rvalid, mem_we} !== 3'b100) begin
      errors++; $display("FAIL rd_after_wr_gnt: gnt/rvalid/we=%b expected 100", {dm_gnt, dm_rvalid, mem_we});
    end
    step();
    dm_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (dm_rvalid !== 1'b1 || rdata !== 32'd100) begin
      errors++; $display("FAIL rd_after_wr_data: rvalid=%b rdata=%0d expected 1 100", dm_rvalid, rdata);
    end
    step();
    @(negedge clk);
    vectors++;
    if (dm_rvalid !== 1'b0 || rdata !== '0) begin
      errors++; $display("FAIL rd_idle_zero: rvalid=%b rdata=%h expected 0 0", dm_rvalid, rdata);
    end
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 10'd120;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd121;
    @(negedge clk);
    vectors++;
    if ({dbg_gnt, dm_gnt, if_gnt} !== 3'b010) begin
      errors++; $display("FAIL cont_c0: gnts=%b expected 010", {dbg_gnt, dm_gnt, if_gnt});
    end
    step();
    dm_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dbg_gnt, dm_gnt, if_gnt} !== 3'b001 || dm_rvalid !== 1'b1 || rdata !== 32'd100) begin
      errors++; $display("FAIL cont_c1: gnts=%b dm_rvalid=%b rdata=%0d expected 001 1 100",
        {dbg_gnt, dm_gnt, if_gnt}, dm_rvalid, rdata);
    end
    step();
    if_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({if_rvalid, dm_rvalid} !== 2'b10 || rdata !== 32'd55) begin
      errors++; $display("FAIL cont_c2: if/dm rvalid=%b rdata=%0d expected 10 55", {if_rvalid, dm_rvalid}, rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic exp_if;
    for (int i = 0; i < 10; i++) begin
      if_req = 1'b1; if_addr = 10'd120;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd121;
      exp_if = GUARD && (i == 4 || i == 9);
      @(negedge clk);
      vectors++;
      if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
        errors++; $display("FAIL starve_cycle%0d: if/dm gnt=%b expected %b", i, {if_gnt, dm_gnt}, {exp_if, ~exp_if});
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lock_after_if();
    if_req = 1'b1; if_addr = 10'd120;
    @(negedge clk);
    vectors++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL lk6_if_gnt: got %b expected 1", if_gnt); end
    step();
    if_req = 1'b0; dbg_lock = 1'b1;
    @(negedge clk);
    vectors++;
    if (if_rvalid !== 1'b1 || rdata !== 32'd55) begin
      errors++; $display("FAIL lk6_if_rvalid: rvalid=%b rdata=%0d expected 1 55", if_rvalid, rdata);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
      dbg_req = (i == 2); dbg_we = 1'b0; dbg_addr = 10'd121;
      @(negedge clk);
      vectors++;
      if ({dbg_gnt, dm_gnt, if_gnt} !== {(i == 2), 2'b00}) begin
        errors++; $display("FAIL lk6_locked%0d: gnts=%b expected %b", i, {dbg_gnt, dm_gnt, if_gnt}, {(i == 2), 2'b00});
      end
      step();
    end
    dbg_req = 1'b0; dbg_lock = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dbg_rvalid, dm_gnt, if_gnt} !== 3'b100 || rdata !== 32'd100) begin
      errors++; $display("FAIL lk6_release: rvalid/dm/if=%b rdata=%0d expected 100 100", {dbg_rvalid, dm_gnt, if_gnt}, rdata);
    end
    step();
    @(negedge clk);
    vectors++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL lk6_resume: dm_gnt=%b expected 1", dm_gnt); end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_random();
    logic [DW-1:0] mem_m [16];
    bit locked_m;
    bit pend_v;
    logic [2:0] pend_who, exp_g, exp_rv;
    logic [3:0] pend_addr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd, exp_rd;
    logic exp_we;
    int starve_m;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    locked_m = 1'b0; pend_v = 1'b0; pend_who = 3'b000; pend_addr = 4'd0; starve_m = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if_req = 1'($urandom_range(0, 1));
      if_addr = 10'($urandom_range(0, 15));
      dm_req = 1'($urandom_range(0, 1));
      dm_we = 1'($urandom_range(0, 1));
      dm_addr = 10'($urandom_range(0, 15));
      dm_wdata = $urandom;
      dbg_req = ($urandom_range(0, 3) == 0);
      dbg_we = 1'($urandom_range(0, 1));
      dbg_addr = 10'($urandom_range(0, 15));
      dbg_wdata = $urandom;
      if ($urandom_range(0, 11) == 0) dbg_lock = ~dbg_lock;
      if (dbg_req) exp_g = 3'b100;
      else if (locked_m) exp_g = 3'b000;
      else if (GUARD && if_req && starve_m >= SMAX) exp_g = 3'b001;
      else if (dm_req) exp_g = 3'b010;
      else if (if_req) exp_g = 3'b001;
      else exp_g = 3'b000;
      exp_we = (exp_g == 3'b100) ? dbg_we : (exp_g == 3'b010) ? dm_we : 1'b0;
      exp_addr = (exp_g == 3'b100) ? dbg_addr : (exp_g == 3'b010) ? dm_addr : (exp_g == 3'b001) ? if_addr : '0;
      exp_wd = (exp_g == 3'b100) ? dbg_wdata : dm_wdata;
      exp_rv = pend_v ? pend_who : 3'b000;
      exp_rd = pend_v ? mem_m[pend_addr] : '0;
      @(negedge clk);
      vectors++;
      if ({dbg_gnt, dm_gnt, if_gnt} !== exp_g) begin
        errors++; $display("FAIL rnd_gnt@%0d: got %b expected %b", n, {dbg_gnt, dm_gnt, if_gnt}, exp_g);
      end
      vectors++;
      if ({mem_en, mem_we, mem_addr} !== {(exp_g != 3'b000), exp_we, exp_addr}) begin
        errors++; $display("FAIL rnd_port@%0d: en/we=%b addr=%0d expected %b %0d", n,
          {mem_en, mem_we}, mem_addr, {(exp_g != 3'b000), exp_we}, exp_addr);
      end
      if (exp_we) begin
        vectors++;
        if (mem_wdata !== exp_wd) begin
          errors++; $display("FAIL rnd_wdata@%0d: got %h expected %h", n, mem_wdata, exp_wd);
        end
      end
      vectors++;
      if ({dbg_rvalid, dm_rvalid, if_rvalid} !== exp_rv || rdata !== exp_rd) begin
        errors++; $display("FAIL rnd_read@%0d: rvalid=%b rdata=%h expected %b %h", n,
          {dbg_rvalid, dm_rvalid, if_rvalid}, rdata, exp_rv, exp_rd);
      end
      pend_v = (exp_g != 3'b000) && !exp_we;
      pend_who = exp_g;
      pend_addr = exp_addr[3:0];
      if (exp_we) mem_m[exp_addr[3:0]] = exp_wd;
      if (!if_req || exp_g == 3'b001) starve_m = 0;
      else if (!locked_m && starve_m < SMAX) starve_m++;
      locked_m = dbg_lock;
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    mem_rdata = '0;
    clk = 1'b0;
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_dbg_lock_load();
    test_write_read();
    test_contention();
    test_starvation();
    test_lock_after_if();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
